crc_engine: RTL and testbench

//  Parametrised multi-bit-per-cycle CRC generator/checker for the replay buffer datapath.

---
 rtl/crc_engine.sv | 116 +++++++++++
 tb/tb_crc_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// crc_engine: multi-bit-per-cycle CRC generator/checker, MSB first, framed {data,crc} output
module crc_engine #(
  parameter int DATA_W = 96,
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = 16'h1021,
  parameter logic [CRC_W-1:0] INIT = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT = 16'h0000,
  parameter int BPC = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      mode,
  input  logic [DATA_W-1:0]         data,
  input  logic [CRC_W-1:0]          crc_in,
  output logic                      busy,
  output logic                      rdy,
  output logic [CRC_W-1:0]          q,
  output logic [DATA_W+CRC_W-1:0]   dataOut,
  output logic                      crc_err
);
  localparam int N = DATA_W / BPC;
  localparam int CNT_W = $clog2(N + 1);
  if (BPC < 1 || BPC > DATA_W || DATA_W % BPC != 0) begin : g_bad_bpc
    $error("crc_engine: BPC must divide DATA_W");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_in_q, crc_in_d, q_q, q_d, fold, fin;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic [DATA_W+CRC_W-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, busy_q, busy_d, rdy_q, rdy_d, err_q, err_d;
  // BPC serial steps unrolled into one combinational fold, MSB of the shift register first
  always_comb begin
    fold = crc_q;
    for (int i = 0; i < BPC; i++)
      fold = {fold[CRC_W-2:0], 1'b0} ^ ((fold[CRC_W-1] ^ sh_q[DATA_W-1-i]) ? POLY : '0);
  end
  assign fin = crc_q ^ XOROUT;
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    sh_d = sh_q;
    data_d = data_q;
    crc_in_d = crc_in_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    rdy_d = 1'b0;
    q_d = q_q;
    dout_d = dout_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (we) begin
        state_d = RUN;
        data_d = data;
        sh_d = data;
        mode_d = mode;
        crc_in_d = crc_in;
        crc_d = INIT;
        cnt_d = '0;
        busy_d = 1'b1;
      end
      RUN: begin
        crc_d = fold;
        sh_d = sh_q << BPC;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(N - 1)) ? DONE : RUN;
      end
      DONE: begin
        q_d = fin;
        dout_d = {data_q, fin};
        err_d = mode_q & (fin != crc_in_q);
        rdy_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      crc_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      crc_in_q <= '0;
      mode_q <= 1'b0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      rdy_q <= 1'b0;
      q_q <= '0;
      dout_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      sh_q <= sh_d;
      data_q <= data_d;
      crc_in_q <= crc_in_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      rdy_q <= rdy_d;
      q_q <= q_d;
      dout_q <= dout_d;
      err_q <= err_d;
    end
  end
  assign busy = busy_q;
  assign rdy = rdy_q;
  assign q = q_q;
  assign dataOut = dout_q;
  assign crc_err = err_q;
endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: randomized and directed checks of crc_engine against a polynomial-division model
module tb_crc_engine;
  logic clk = 0, rst = 0;
  logic we72 = 0, mode72 = 0, we96 = 0, mode96 = 0;
  logic [71:0] data72 = '0;
  logic [95:0] data96 = '0;
  logic [15:0] crcin72 = '0, crcin96 = '0;
  logic busy_a, rdy_a, err_a, busy_b, rdy_b, err_b, busy_c, rdy_c, err_c, busy_d, rdy_d, err_d;
  logic [15:0] q_a, q_b, q_c, q_d;
  logic [87:0] do_a, do_b, do_c;
  logic [111:0] do_d;
  int n_vec = 0, n_err = 0, edge_n = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;
  int edg_a = 0, edg_b = 0, edg_c = 0, edg_d = 0;
  int acc, pa, pb, pc, pd;
  localparam logic [71:0] STR = 72'h313233343536373839;

  crc_engine #(.DATA_W(72), .BPC(8)) u_a (.clk(clk), .rst(rst), .we(we72), .mode(mode72), .data(data72),
    .crc_in(crcin72), .busy(busy_a), .rdy(rdy_a), .q(q_a), .dataOut(do_a), .crc_err(err_a));
  crc_engine #(.DATA_W(72), .BPC(1)) u_b (.clk(clk), .rst(rst), .we(we72), .mode(mode72), .data(data72),
    .crc_in(crcin72), .busy(busy_b), .rdy(rdy_b), .q(q_b), .dataOut(do_b), .crc_err(err_b));
  crc_engine #(.DATA_W(72), .BPC(72)) u_c (.clk(clk), .rst(rst), .we(we72), .mode(mode72), .data(data72),
    .crc_in(crcin72), .busy(busy_c), .rdy(rdy_c), .q(q_c), .dataOut(do_c), .crc_err(err_c));
  crc_engine u_d (.clk(clk), .rst(rst), .we(we96), .mode(mode96), .data(data96),
    .crc_in(crcin96), .busy(busy_d), .rdy(rdy_d), .q(q_d), .dataOut(do_d), .crc_err(err_d));

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(negedge clk) begin
    if (rdy_a) begin cnt_a <= cnt_a + 1; edg_a <= edge_n; end
    if (rdy_b) begin cnt_b <= cnt_b + 1; edg_b <= edge_n; end
    if (rdy_c) begin cnt_c <= cnt_c + 1; edg_c <= edge_n; end
    if (rdy_d) begin cnt_d <= cnt_d + 1; edg_d <= edge_n; end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as remainder of long division of (message*x^16, INIT xored onto its leading bits) by x^16+POLY
  function automatic logic [15:0] crc_model(input logic [95:0] d, input int len);
    bit m [0:111];
    logic [16:0] gen = {1'b1, 16'h1021};
    logic [15:0] init_v = 16'hFFFF, r;
    for (int i = 0; i < 112; i++) m[i] = 0;
    for (int i = 0; i < len; i++) m[i] = d[len-1-i];
    for (int i = 0; i < 16; i++) m[i] ^= init_v[15-i];
    for (int i = 0; i < len; i++)
      if (m[i]) for (int j = 0; j <= 16; j++) m[i+j] ^= gen[16-j];
    for (int i = 0; i < 16; i++) r[15-i] = m[len+i];
    return r ^ 16'h0000;
  endfunction

  task automatic wait_d(input int prev);
    int k = 0;
    while (cnt_d == prev && k < 100) begin @(negedge clk); #1; k++; end
    if (cnt_d == prev) chk("timeout_d", cnt_d, prev + 1);
  endtask

  task automatic wait72();
    int k = 0;
    while ((cnt_a == pa || cnt_b == pb || cnt_c == pc) && k < 120) begin @(negedge clk); #1; k++; end
    chk("rdy_a_count", cnt_a, pa + 1);
    chk("rdy_b_count", cnt_b, pb + 1);
    chk("rdy_c_count", cnt_c, pc + 1);
  endtask

  task automatic go96(input logic [95:0] d, input logic m, input logic [15:0] c);
    @(negedge clk);
    data96 = d; mode96 = m; crcin96 = c; we96 = 1; acc = edge_n + 1; pd = cnt_d;
    @(negedge clk);
    we96 = 0; data96 = {$urandom, $urandom, $urandom}; mode96 = ~m; crcin96 = ~c;
  endtask

  task automatic go72(input logic m, input logic [15:0] c);
    @(negedge clk);
    data72 = STR; mode72 = m; crcin72 = c; we72 = 1; acc = edge_n + 1;
    pa = cnt_a; pb = cnt_b; pc = cnt_c;
    @(negedge clk);
    we72 = 0; data72 = '1; mode72 = ~m; crcin72 = ~c;
  endtask

  task automatic check96(input string t, input logic [95:0] d, input logic m, input logic [15:0] c);
    logic [15:0] e;
    e = crc_model(d, 96);
    wait_d(pd);
    chk({t, "_q"}, q_d, e);
    chk({t, "_dataOut"}, do_d, {d, e});
    chk({t, "_err"}, err_d, m & (e != c));
    chk({t, "_lat"}, edg_d, acc + 13);
    chk({t, "_busy"}, busy_d, 0);
  endtask

  initial begin
    logic [95:0] x, y;
    logic [15:0] c;
    logic m;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_d, 0);
    chk("rst_rdy", rdy_d, 0);
    chk("rst_q", q_d, 0);
    chk("rst_dataOut", do_d, 0);
    chk("rst_err", err_d, 0);
    rst = 1;
    go72(0, 16'h0);
    wait72();
    chk("gen8_q", q_a, 16'h29B1);
    chk("gen8_dataOut", do_a, {STR, 16'h29B1});
    chk("gen8_err", err_a, 0);
    chk("gen8_lat", edg_a, acc + 10);
    chk("gen1_q", q_b, 16'h29B1);
    chk("gen1_lat", edg_b, acc + 73);
    chk("gen72_q", q_c, 16'h29B1);
    chk("gen72_lat", edg_c, acc + 2);
    chk("gen72_dataOut", do_c, {STR, 16'h29B1});
    go72(1, 16'h29B1);
    wait72();
    chk("chk_ok_err_a", err_a, 0);
    chk("chk_ok_err_b", err_b, 0);
    chk("chk_ok_q", q_a, 16'h29B1);
    go72(1, 16'h29B0);
    wait72();
    chk("chk_bad_err_a", err_a, 1);
    chk("chk_bad_err_b", err_b, 1);
    chk("chk_bad_err_c", err_c, 1);
    chk("chk_bad_q", q_a, 16'h29B1);
    x = 96'h111122223333444455556666;
    go96(x, 0, 16'h0);
    repeat (4) @(negedge clk);
    we96 = 1; data96 = ~x;
    @(negedge clk);
    we96 = 0;
    check96("dflt", x, 0, 16'h0);
    repeat (20) @(negedge clk);
    #1;
    chk("dflt_no_extra_rdy", cnt_d, pd + 1);
    for (int i = 0; i < 8; i++) begin
      x = {$urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 1) ? crc_model(x, 96) : 16'($urandom);
      go96(x, m, c);
      check96($sformatf("rnd%0d", i), x, m, c);
    end
    x = {$urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom};
    @(negedge clk);
    data96 = x; mode96 = 0; we96 = 1; acc = edge_n + 1; pd = cnt_d;
    @(negedge clk);
    data96 = y;
    wait_d(pd);
    chk("b2b_first_q", q_d, crc_model(x, 96));
    chk("b2b_first_lat", edg_d, acc + 13);
    @(negedge clk);
    #1;
    we96 = 0;
    chk("b2b_accepted", busy_d, 1);
    chk("b2b_hold_q", q_d, crc_model(x, 96));
    chk("b2b_hold_dataOut", do_d, {x, crc_model(x, 96)});
    pd = cnt_d;
    wait_d(pd);
    chk("b2b_second_q", q_d, crc_model(y, 96));
    chk("b2b_second_dataOut", do_d, {y, crc_model(y, 96)});
    chk("b2b_second_lat", edg_d, acc + 27);
    go96({$urandom, $urandom, $urandom}, 1, 16'h1234);
    @(negedge clk);
    #1;
    rst = 0;
    #1;
    chk("mid_rst_busy", busy_d, 0);
    chk("mid_rst_rdy", rdy_d, 0);
    chk("mid_rst_q", q_d, 0);
    chk("mid_rst_dataOut", do_d, 0);
    chk("mid_rst_err", err_d, 0);
    @(negedge clk);
    rst = 1;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_rst_no_rdy", cnt_d, pd);
    chk("mid_rst_idle", busy_d, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
